alu_op_sequencer: RTL and testbench

- Command-side controller that drives the 16-bit combinational ALU's A/B/Op inputs and captures its Y and C/V/N/Z outputs.
- Holds an 8 x 16 register file and a 4-bit status register.
- Accepts one register-to-register command at a time over a valid/ready handshake and returns the result and flags over a second valid/ready handshake.
- Sits between the instruction front end and the ALU instance.

---
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 16-bit ALU: 8x16 register file, {C,V,N,Z} status, cmd/rsp handshakes.
// Optional build macro ALU_SEQ_ILLEGAL_TRAP_EN rejects reserved op codes with rsp_err.
module alu_op_sequencer #(
    parameter int unsigned NREG = 8,
    parameter int unsigned W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [2:0]   cmd_ra,
    input  logic [2:0]   cmd_rb,
    input  logic [2:0]   cmd_rd,
    input  logic [W-1:0] cmd_imm,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_y,
    input  logic         alu_c,
    input  logic         alu_v,
    input  logic         alu_n,
    input  logic         alu_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic [3:0]   status
);

    localparam int unsigned AW  = 3;
    localparam int unsigned FW  = 4;
    localparam int unsigned OPW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [OPW-1:0] OP_LDI = 4'b1111;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic           r_cmd_ready;
    logic           r_rsp_valid;
    logic [W-1:0]   r_regs [NREG];
    logic [FW-1:0]  r_status;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [OPW-1:0] r_alu_op;
    logic [AW-1:0]  r_rd;
    logic [W-1:0]   r_imm;
    logic [W-1:0]   r_rsp_data;
    logic [FW-1:0]  r_rsp_flags;

    logic           w_accept;
    logic           w_incdec;
    logic           w_arith;
    logic           w_ldi;
    logic           w_trap;
    logic [FW-1:0]  w_status_nxt;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_incdec = (cmd_op[3:1] == 3'b000);
    assign w_arith  = (r_alu_op[3:2] == 2'b00);
    assign w_ldi    = (r_alu_op == OP_LDI);

    // Logic ops (and untrapped reserved codes) keep C/V, take N/Z from the ALU.
    assign w_status_nxt = w_arith ? {alu_c, alu_v, alu_n, alu_z}
                                  : {r_status[3:2], alu_n, alu_z};

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic r_trap;
    logic r_rsp_err;
    logic w_cmd_reserved;

    assign w_cmd_reserved = !((cmd_op[3:2] == 2'b00) || (cmd_op == 4'b1001) ||
                              (cmd_op == 4'b1010) || (cmd_op == 4'b1011) ||
                              (cmd_op == OP_LDI));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap    <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_trap <= w_cmd_reserved;
            end
            if (r_state == S_ISSUE) begin
                r_rsp_err <= r_trap;
            end
        end
    end

    assign w_trap  = r_trap;
    assign rsp_err = r_rsp_err;
`else
    assign w_trap  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register plus registered handshake outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture at accept; result/status write-back at the end of ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs      <= '{default: '0};
            r_status    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= r_regs[cmd_ra];
                r_alu_b  <= w_incdec ? W'(1) : r_regs[cmd_rb];
                r_alu_op <= cmd_op;
                r_rd     <= cmd_rd;
                r_imm    <= cmd_imm;
            end
            if (r_state == S_ISSUE) begin
                if (w_trap) begin
                    r_rsp_data  <= '0;
                    r_rsp_flags <= r_status;
                end else if (w_ldi) begin
                    r_regs[r_rd] <= r_imm;
                    r_rsp_data   <= r_imm;
                    r_rsp_flags  <= r_status;
                end else begin
                    r_regs[r_rd] <= alu_y;
                    r_status     <= w_status_nxt;
                    r_rsp_data   <= alu_y;
                    r_rsp_flags  <= w_status_nxt;
                end
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign status    = r_status;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stub, directed table, corner sequences, random run.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_ra;
    logic [2:0]  cmd_rb;
    logic [2:0]  cmd_rd;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_y;
    logic        alu_c;
    logic        alu_v;
    logic        alu_n;
    logic        alu_z;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [3:0]  status;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .status(status)
    );

    // ALU stub: returns {C,V,N,Z,Y}. Reserved codes give a recognisable pattern;
    // logic ops drive C/V from result bits so a wrong C/V update shows up.
    function automatic logic [19:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        logic [16:0] r;
        logic [15:0] y;
        logic        c;
        logic        v;
        r = '0;
        case (op)
            4'd0: r = {1'b0, a} + 17'd1;
            4'd1: r = {1'b0, a} - 17'd1;
            4'd2: r = {1'b0, a} - {1'b0, b};
            4'd3: r = {1'b0, a} + {1'b0, b};
            4'd9:  r = {1'b0, a & b};
            4'd10: r = {1'b0, a | b};
            4'd11: r = {1'b0, ~(a ^ b)};
            default: r = {1'b0, a ^ b ^ 16'h5A5A};
        endcase
        y = r[15:0];
        case (op)
            4'd0: begin c = r[16]; v = !a[15] && y[15]; end
            4'd1: begin c = r[16]; v = a[15] && !y[15]; end
            4'd2: begin c = r[16]; v = (a[15] != b[15]) && (y[15] != a[15]); end
            4'd3: begin c = r[16]; v = (a[15] == b[15]) && (y[15] != a[15]); end
            default: begin c = y[0]; v = y[1]; end
        endcase
        return {c, v, y[15], (y == 16'h0000), y};
    endfunction

    always_comb {alu_c, alu_v, alu_n, alu_z, alu_y} = alu_fn(alu_a, alu_b, alu_op);

    // Architectural reference state
    logic [15:0] m_regs [8];
    logic [3:0]  m_status;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_status = 4'h0;
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                              input logic [2:0] rd, input logic [15:0] imm,
                              output logic [15:0] ea, output logic [15:0] eb,
                              output logic [15:0] ed, output logic [3:0] ef, output logic ee);
        logic [19:0] res;
        logic        reserved;
        logic        trap;
        ea = m_regs[ra];
        eb = (op == 4'd0 || op == 4'd1) ? 16'h0001 : m_regs[rb];
        res = alu_fn(ea, eb, op);
        reserved = !(op <= 4'd3 || op == 4'd9 || op == 4'd10 || op == 4'd11 || op == 4'd15);
        trap = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        trap = reserved;
`endif
        ee = trap;
        if (trap) begin
            ed = 16'h0000;
        end else if (op == 4'd15) begin
            m_regs[rd] = imm;
            ed = imm;
        end else if (op <= 4'd3) begin
            m_status = res[19:16];
            m_regs[rd] = res[15:0];
            ed = res[15:0];
        end else begin
            m_status = {m_status[3:2], res[17:16]};
            m_regs[rd] = res[15:0];
            ed = res[15:0];
        end
        ef = m_status;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One full command: present, check ISSUE cycle, check response, optional stall, handshake.
    task automatic do_cmd(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] rd, input logic [15:0] imm, input int hold,
                          input bit keep, output logic [15:0] od, output logic [3:0] of,
                          output logic oe);
        logic [15:0] ea, eb, ed;
        logic [3:0]  ef;
        logic        ee;
        int          waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        model_exec(op, ra, rb, rd, imm, ea, eb, ed, ef, ee);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = keep;
        check("issue_cmd_ready", 32'(cmd_ready), 32'd0);
        check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        check("issue_alu_a", 32'(alu_a), 32'(ea));
        check("issue_alu_b", 32'(alu_b), 32'(eb));
        check("issue_alu_op", 32'(alu_op), 32'(op));
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rsp_flags", 32'(rsp_flags), 32'(ef));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("status", 32'(status), 32'(m_status));
        od = rsp_data; of = rsp_flags; oe = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_data", 32'(rsp_data), 32'(od));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] od;
        logic [3:0]  of;
        logic        oe;

        tbl[0] = '{op: 4'd15, ra: 3'd0, rb: 3'd0, rd: 3'd1, imm: 16'h7FFF, data: 16'h7FFF, flags: 4'b0000, err: 1'b0};
        tbl[1] = '{op: 4'd3,  ra: 3'd1, rb: 3'd1, rd: 3'd2, imm: 16'h0000, data: 16'hFFFE, flags: 4'b0110, err: 1'b0};
        tbl[2] = '{op: 4'd15, ra: 3'd0, rb: 3'd0, rd: 3'd3, imm: 16'h0000, data: 16'h0000, flags: 4'b0110, err: 1'b0};
        tbl[3] = '{op: 4'd1,  ra: 3'd3, rb: 3'd0, rd: 3'd3, imm: 16'h0000, data: 16'hFFFF, flags: 4'b1010, err: 1'b0};
        tbl[4] = '{op: 4'd0,  ra: 3'd3, rb: 3'd0, rd: 3'd3, imm: 16'h0000, data: 16'h0000, flags: 4'b1001, err: 1'b0};
        tbl[5] = '{op: 4'd9,  ra: 3'd3, rb: 3'd0, rd: 3'd4, imm: 16'h0000, data: 16'h0000, flags: 4'b1001, err: 1'b0};
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        tbl[6] = '{op: 4'd5,  ra: 3'd1, rb: 3'd1, rd: 3'd6, imm: 16'h0000, data: 16'h0000, flags: 4'b1001, err: 1'b1};
        tbl[7] = '{op: 4'd10, ra: 3'd6, rb: 3'd6, rd: 3'd7, imm: 16'h0000, data: 16'h0000, flags: 4'b1001, err: 1'b0};
`else
        tbl[6] = '{op: 4'd5,  ra: 3'd1, rb: 3'd1, rd: 3'd6, imm: 16'h0000, data: 16'h5A5A, flags: 4'b1000, err: 1'b0};
        tbl[7] = '{op: 4'd10, ra: 3'd6, rb: 3'd6, rd: 3'd7, imm: 16'h0000, data: 16'h5A5A, flags: 4'b1000, err: 1'b0};
`endif

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
        cmd_imm = '0; rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_status", 32'(status), 32'd0);
        check("reset_alu_a", 32'(alu_a), 32'd0);
        check("reset_alu_b", 32'(alu_b), 32'd0);
        check("reset_alu_op", 32'(alu_op), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_flags", 32'(rsp_flags), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);

        // Directed vectors from the test plan
        for (int i = 0; i < 8; i++) begin
            do_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].imm, 0, 1'b0, od, of, oe);
            check($sformatf("tbl%0d_data", i), 32'(od), 32'(tbl[i].data));
            check($sformatf("tbl%0d_flags", i), 32'(of), 32'(tbl[i].flags));
            check($sformatf("tbl%0d_err", i), 32'(oe), 32'(tbl[i].err));
        end

        // Response stalled 5 cycles with cmd_valid held, then back-to-back accept
        do_cmd(4'd3, 3'd1, 3'd1, 3'd2, 16'h0000, 5, 1'b1, od, of, oe);
        check("stall_data", 32'(od), 32'hFFFE);
        do_cmd(4'd10, 3'd2, 3'd2, 3'd0, 16'h0000, 0, 1'b0, od, of, oe);
        check("after_stall_data", 32'(od), 32'hFFFE);

        // Reset while ADD R5 = R1 + R1 sits in ISSUE
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_rd = 3'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_status", 32'(status), 32'd0);
        do_cmd(4'd10, 3'd5, 3'd5, 3'd0, 16'h0000, 0, 1'b0, od, of, oe);
        check("midrst_r5", 32'(od), 32'd0);

        // Random commands against the reference model
        for (int n = 0; n < 300; n++) begin
            do_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), od, of, oe);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
